// File: rtl/vrf_pkg.sv
// Shared types for the VRF operand fetch path; the data typedefs reflect the default build
// (1024 x 32 SRAM, 8-bit burst length).
package vrf_pkg;

  localparam int unsigned NumWordsDef  = 1024;
  localparam int unsigned DataWidthDef = 32;
  localparam int unsigned LenWidthDef  = 8;

  // Address width rule shared with the SRAM macro wrapper.
  function automatic int unsigned addr_width(input int unsigned num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

  localparam int unsigned AddrWidthDef = addr_width(NumWordsDef);

  typedef logic [AddrWidthDef-1:0] addr_t;
  typedef logic [DataWidthDef-1:0] data_t;
  typedef logic [LenWidthDef-1:0]  len_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic valid;
    logic last;
  } pipe_entry_t;

endpackage

// File: rtl/vrf_fetch_fifo.sv
// Synchronous operand FIFO holding {last, data}; the head is visible combinationally and
// count feeds the issue credit. Push and pop in the same cycle are legal even when full.
module vrf_fetch_fifo #(
  parameter  int unsigned Depth = 4,
  parameter  int unsigned Width = 32,
  localparam int unsigned CntW  = $clog2(Depth + 1),
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic [Width-1:0] data,
  output logic             last,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width:0]    mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              full;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign data  = mem_q[rd_ptr_q][Width-1:0];
  assign last  = mem_q[rd_ptr_q][Width];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {push_last, push_data};
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
    else $fatal(1, "vrf_fetch_fifo: push while full");
  a_no_underflow : assert property (@(posedge clk) disable iff (rst) !(pop && empty))
    else $fatal(1, "vrf_fetch_fifo: pop while empty");

endmodule

// File: rtl/vrf_operand_fetch.sv
// Burst read sequencer for one VRF SRAM read port, credit-throttled into an operand FIFO.
// Optional per-burst address stride enabled by defining VRF_FETCH_STRIDE_EN.
module vrf_operand_fetch
  import vrf_pkg::*;
#(
  parameter  int unsigned NumWords  = 1024,
  parameter  int unsigned DataWidth = 32,
  parameter  int unsigned Latency   = 1,
  parameter  int unsigned FifoDepth = 4,
  parameter  int unsigned LenWidth  = 8,
  localparam int unsigned AddrWidth = addr_width(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [LenWidth-1:0]  cmd_len_i,
`ifdef VRF_FETCH_STRIDE_EN
  input  logic [AddrWidth-1:0] cmd_stride_i,
`endif
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  input  logic [DataWidth-1:0] sram_rdata_i,
  output logic                 op_valid_o,
  input  logic                 op_ready_i,
  output logic [DataWidth-1:0] op_data_o,
  output logic                 op_last_o,
  output logic                 busy_o
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam logic [AddrWidth:0] NumWordsExt = (AddrWidth + 1)'(NumWords);

  if (Latency < 1) begin : g_bad_latency
    $fatal(1, "vrf_operand_fetch: Latency must be at least 1");
  end

  fetch_state_e         state_q, state_d;
  logic [AddrWidth-1:0] addr_q;
  logic [LenWidth-1:0]  remain_q;
  logic [CntW-1:0]      inflight_q;
  logic [CntW-1:0]      fifo_count;
  logic                 fifo_empty;
  pipe_entry_t          pipe_q [Latency];
  pipe_entry_t          pipe_out;

  logic                 cmd_fire;
  logic                 cmd_start;
  logic                 credit;
  logic                 issue;
  logic                 issue_last;
  logic                 pop;
  logic [AddrWidth-1:0] step;
  logic [AddrWidth:0]   addr_sum;
  logic [AddrWidth-1:0] addr_next;

  // Ready is forced low while reset is asserted so nothing is accepted during it.
  assign cmd_ready_o = (state_q == IDLE) && !rst_i;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign cmd_start   = cmd_fire && (cmd_len_i != '0);

  assign credit     = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CntW + 1)'(FifoDepth);
  assign issue      = (state_q == ISSUE) && credit;
  assign issue_last = issue && (remain_q == LenWidth'(1));

  assign sram_req_o  = issue;
  assign sram_we_o   = 1'b0;
  assign sram_addr_o = addr_q;

`ifdef VRF_FETCH_STRIDE_EN
  logic [AddrWidth-1:0] stride_q;
  logic [AddrWidth:0]   stride_ext;
  logic [AddrWidth-1:0] stride_mod;

  // A single subtraction suffices: the raw stride is below 2*NumWords.
  assign stride_ext = {1'b0, cmd_stride_i};
  assign stride_mod = (stride_ext >= NumWordsExt) ? AddrWidth'(stride_ext - NumWordsExt)
                                                  : cmd_stride_i;
  assign step       = stride_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stride_q <= '0;
    end else if (cmd_start) begin
      stride_q <= stride_mod;
    end
  end
`else
  assign step = AddrWidth'(1);
`endif

  // Explicit wrap keeps non-power-of-two SRAM depths correct.
  always_comb begin
    addr_sum = {1'b0, addr_q} + {1'b0, step};
    if (addr_sum >= NumWordsExt) begin
      addr_next = AddrWidth'(addr_sum - NumWordsExt);
    end else begin
      addr_next = addr_sum[AddrWidth-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_start)  state_d = ISSUE;
      ISSUE:   if (issue_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_start) begin
        addr_q   <= cmd_addr_i;
        remain_q <= cmd_len_i;
      end else if (issue) begin
        addr_q   <= addr_next;
        remain_q <= remain_q - LenWidth'(1);
      end
    end
  end

  // Tags travel alongside the SRAM access so data and last line up on exit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Latency; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= '{valid: issue, last: issue_last};
      for (int i = 1; i < Latency; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign pipe_out = pipe_q[Latency-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= '0;
    end else if (issue && !pipe_out.valid) begin
      inflight_q <= inflight_q + CntW'(1);
    end else if (!issue && pipe_out.valid) begin
      inflight_q <= inflight_q - CntW'(1);
    end
  end

  assign op_valid_o = !fifo_empty;
  assign pop        = op_valid_o && op_ready_i;

  vrf_fetch_fifo #(
    .Depth (FifoDepth),
    .Width (DataWidth)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (pipe_out.valid),
    .push_data (sram_rdata_i),
    .push_last (pipe_out.last),
    .pop       (pop),
    .data      (op_data_o),
    .last      (op_last_o),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign busy_o = (state_q != IDLE) || (inflight_q != '0) || !fifo_empty;

endmodule

// File: tb/tb_vrf_operand_fetch.sv
// Directed bench for vrf_operand_fetch against a 1-cycle SRAM preloaded with mem[i]=i;
// a monitor pops expected operands from a scoreboard queue on every accepted transfer.
module tb_vrf_operand_fetch;

  localparam int NW  = 1024;
  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int LW  = 8;
  localparam int FD  = 4;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] cmd_stride;
  logic          sram_req;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata;
  logic          op_valid;
  logic          op_ready;
  logic [DW-1:0] op_data;
  logic          op_last;
  logic          busy;

  int checks;
  int failures;
  int cyc;
  int req_cnt;
  int pop_cnt;
  int pop_cyc[$];
  logic [DW:0] expq[$];
  logic [DW-1:0] mem [NW];

  vrf_operand_fetch #(
    .NumWords  (NW),
    .DataWidth (DW),
    .Latency   (1),
    .FifoDepth (FD),
    .LenWidth  (LW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_len_i    (cmd_len),
`ifdef VRF_FETCH_STRIDE_EN
    .cmd_stride_i (cmd_stride),
`endif
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_rdata_i (sram_rdata),
    .op_valid_o   (op_valid),
    .op_ready_i   (op_ready),
    .op_data_o    (op_data),
    .op_last_o    (op_last),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = DW'(i);
    sram_rdata = '0;
  end

  // SRAM: one-cycle read latency, read data held while idle.
  always @(posedge clk) begin
    if (sram_req && !sram_we) sram_rdata <= mem[sram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: sampled mid-cycle, so a valid&&ready seen here transfers at the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (sram_req) req_cnt++;
      if (op_valid && op_ready) begin
        pop_cnt++;
        pop_cyc.push_back(cyc);
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL op_unexpected actual=%0h expected=none", {op_last, op_data});
        end else begin
          chk("op_word", {31'b0, op_last, op_data}, {31'b0, expq.pop_front()});
        end
      end
    end
  end

  task automatic expect_burst(input int a, input int n, input int step);
    int addr;
    addr = a;
    for (int i = 0; i < n; i++) begin
      expq.push_back({(i == n - 1) ? 1'b1 : 1'b0, DW'(addr)});
      addr = (addr + step) % NW;
    end
  endtask

  task automatic send_cmd(input int a, input int n, input int s);
    bit ok;
    ok = 0;
    @(posedge clk) #1;
    cmd_valid  = 1'b1;
    cmd_addr   = AW'(a);
    cmd_len    = LW'(n);
    cmd_stride = AW'(s);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk) #1;
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept_timeout actual=no_ready expected=ready");
    end
  endtask

  task automatic wait_drain(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (expq.size() == 0) begin
        ok = 1;
        break;
      end
    end
    @(negedge clk);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_drain_timeout actual=%0d expected=0 pending", nm, expq.size());
    end
    chk({nm, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; req_cnt = 0; pop_cnt = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_stride = '0;
    op_ready = 1'b1;

    #12;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_sram_req", sram_req, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sram_we", sram_we, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op_data", op_data, 0);
    chk("rst_op_last", op_last, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);

    // Basic burst, full throughput.
    pop_cyc.delete();
    expect_burst(4, 3, 1);
    send_cmd(4, 3, 1);
    wait_drain("basic");
    chk("basic_pops", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) chk("basic_consecutive", pop_cyc[2] - pop_cyc[0], 2);

    // Address wrap at the top of the SRAM.
    expect_burst(1022, 4, 1);
    send_cmd(1022, 4, 1);
    wait_drain("wrap");

    // Consumer stalled: credit caps outstanding requests at the FIFO depth.
    op_ready = 1'b0;
    req_cnt = 0;
    expect_burst(0, 8, 1);
    send_cmd(0, 8, 1);
    repeat (20) @(negedge clk);
    chk("stall_req_cnt", req_cnt, FD);
    chk("stall_op_valid", op_valid, 1);
    chk("stall_head", op_data, 0);
    @(posedge clk) #1;
    op_ready = 1'b1;
    wait_drain("stall");
    chk("stall_total_req", req_cnt, 8);

    // Zero-length command is a no-op.
    begin
      int pc;
      req_cnt = 0;
      pc = pop_cnt;
      send_cmd(5, 0, 1);
      @(negedge clk);
      chk("len0_cmd_ready", cmd_ready, 1);
      repeat (5) @(negedge clk);
      chk("len0_req_cnt", req_cnt, 0);
      chk("len0_pops", pop_cnt - pc, 0);
      chk("len0_busy", busy, 0);
    end

    // Reset in the middle of a burst discards everything.
    begin
      int pc;
      bit ok;
      ok = 0;
      op_ready = 1'b0;
      req_cnt = 0;
      send_cmd(0, 8, 1);
      for (int i = 0; i < 50; i++) begin
        @(posedge clk) #2;
        if (req_cnt >= 3) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL midrst_issue_timeout actual=%0d expected=3", req_cnt);
      end
      rst = 1'b1;
      #1;
      chk("midrst_cmd_ready", cmd_ready, 0);
      chk("midrst_sram_req", sram_req, 0);
      chk("midrst_sram_addr", sram_addr, 0);
      chk("midrst_op_valid", op_valid, 0);
      chk("midrst_op_data", op_data, 0);
      chk("midrst_op_last", op_last, 0);
      chk("midrst_busy", busy, 0);
      @(posedge clk) #1;
      rst = 1'b0;
      op_ready = 1'b1;
      pc = pop_cnt;
      expect_burst(10, 2, 1);
      send_cmd(10, 2, 1);
      wait_drain("midrst");
      repeat (3) @(negedge clk);
      chk("midrst_pops", pop_cnt - pc, 2);
    end

`ifdef VRF_FETCH_STRIDE_EN
    expect_burst(2, 3, 5);
    send_cmd(2, 3, 5);
    wait_drain("stride");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
